// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory-side datapath: data word, RAM status
// encoding and the memory arbiter state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FAIR_CNT_W = 2;

  // Number of consecutive data grants tolerated while an ifetch waits.
  localparam logic [FAIR_CNT_W-1:0] FAIR_LIMIT = FAIR_CNT_W'(3);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Access timeout counter: counts owning cycles, clears while the arbiter idles,
// and flags the last permitted cycle of an unresolved access.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter; saturates at the last permitted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side arbiter between the icache and dcache request ports onto a
// single-ported RAM. Data requests win over instruction requests; a grant is
// held until the RAM completes, errors, times out or the owner withdraws.
// Optional macro ARB_FAIR_EN: after three consecutive data grants that left an
// instruction request waiting, the next arbitration goes to the icache.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);

  arb_state_t state;
  arb_state_t state_next;
  ramstate_t  rs;
  logic       d_req;
  logic       err_set;
  logic       timer_expired;
  logic       fair_force_i;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dREN | dWEN;

  // Load data is a straight pass-through; qualified by the wait signals.
  assign iload = ramload;
  assign dload = ramload;

  mem_arb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .expired (timer_expired)
  );

`ifdef ARB_FAIR_EN
  logic [FAIR_CNT_W-1:0] fair_cnt;

  assign fair_force_i = iREN && (fair_cnt == FAIR_LIMIT);

  // Count consecutive data grants that left an instruction request waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fair_cnt <= '0;
    end else if ((state == IDLE) && (state_next == I_ACC)) begin
      fair_cnt <= '0;
    end else if ((state == IDLE) && (state_next == D_ACC)) begin
      if (!iREN) begin
        fair_cnt <= '0;
      end else if (fair_cnt != FAIR_LIMIT) begin
        fair_cnt <= fair_cnt + FAIR_CNT_W'(1);
      end
    end
  end
`else
  assign fair_force_i = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sticky error flag: RAM error or access timeout.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      arb_err <= 1'b0;
    end else if (err_set) begin
      arb_err <= 1'b1;
    end
  end

  // Arbitration, RAM strobes and completion signalling.
  always_comb begin
    state_next = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !fair_force_i) begin
          state_next = D_ACC;
        end else if (iREN) begin
          state_next = I_ACC;
        end
      end
      D_ACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = ~dWEN;
          if (rs == ACCESS) begin
            dwait      = 1'b0;
            state_next = IDLE;
          end else if ((rs == ERROR) || timer_expired) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      I_ACC: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_next = IDLE;
        end else begin
          ramREN = 1'b1;
          if (rs == ACCESS) begin
            iwait      = 1'b0;
            state_next = IDLE;
          end else if ((rs == ERROR) || timer_expired) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level expectations are queued
// when requests are issued and a negedge monitor checks every wait pulse.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam int MODE_NORMAL = 0, MODE_ERR1 = 1, MODE_HANG = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .nRST(nrst),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  bit          exp_err;
  int          fair_cnt;
  int          mode;
  int          lat;
  int          busy;
  bit          err_done;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: data first, unless the fairness quota is used up.
  task automatic pick(input bit d, input bit i, output bit g_d);
    g_d = d;
    if (d && i) begin
`ifdef ARB_FAIR_EN
      g_d = (fair_cnt != 3);
`else
      g_d = 1'b1;
`endif
    end
    if (!g_d) fair_cnt = 0;
    else if (i) fair_cnt = (fair_cnt == 3) ? 3 : fair_cnt + 1;
    else fair_cnt = 0;
  endtask

  task automatic push_exp(input bit is_d, input bit wr, input logic [31:0] a, input logic [31:0] s);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.addr  = a;
    e.store = s;
    e.load  = wr ? 32'h0 : ref_rd(a);
    if (is_d && wr) ref_mem[a] = s;
    exp_q.push_back(e);
  endtask

  // RAM model: reacts to strobes with a configurable BUSY latency, error or hang.
  initial begin
    ramstate = RS_FREE;
    ramload  = '0;
    busy     = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!(ramREN || ramWEN)) begin
        busy     = 0;
        ramstate = RS_FREE;
        ramload  = $urandom;
      end else if (mode == MODE_HANG) begin
        ramstate = RS_BUSY;
      end else if (mode == MODE_ERR1 && !err_done) begin
        ramstate = RS_ERROR;
        err_done = 1'b1;
      end else if (busy < lat) begin
        ramstate = RS_BUSY;
        ramload  = $urandom;
        busy++;
      end else begin
        ramstate = RS_ACCESS;
        ramload  = ram_rd(ramaddr);
        if (ramWEN) ram_mem[ramaddr] = ramstore;
      end
    end
  end

  // Monitor: every wait pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst && (!dwait || !iwait)) begin
        if (!dwait && !iwait) begin
          chk("both_waits_low", 32'(dwait | iwait), 32'd1);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_wait_pulse", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("owner_is_d", 32'(!dwait), 32'(e.is_d));
          if (e.is_d) begin
            chk("d_ramaddr", ramaddr, e.addr);
            chk("d_ramWEN", 32'(ramWEN), 32'(e.wr));
            chk("d_ramREN", 32'(ramREN), 32'(!e.wr));
            if (e.wr) chk("d_ramstore", ramstore, e.store);
            else chk("dload", dload, e.load);
          end else begin
            chk("i_ramaddr", ramaddr, e.addr);
            chk("i_ramREN", 32'(ramREN), 32'd1);
            chk("i_ramWEN", 32'(ramWEN), 32'd0);
            chk("iload", iload, e.load);
          end
          chk("arb_err_at_completion", 32'(arb_err), 32'(exp_err));
        end
      end
    end
  end

  task automatic do_round(input bit want_d, input bit wr, input bit rd_too,
                          input logic [31:0] da, input logic [31:0] ds,
                          input bit want_i, input logic [31:0] ia,
                          input int L, input int extra);
    bit g;
    int n;
    int last;
    bit d_done, i_done;
    lat = L;
    n = 0;
    if (want_d && want_i) begin
      pick(1'b1, 1'b1, g);
      if (g) begin
        push_exp(1'b1, wr, da, ds);
        pick(1'b0, 1'b1, g);
        push_exp(1'b0, 1'b0, ia, 32'h0);
      end else begin
        push_exp(1'b0, 1'b0, ia, 32'h0);
        pick(1'b1, 1'b0, g);
        push_exp(1'b1, wr, da, ds);
      end
      n = 2;
    end else if (want_d) begin
      pick(1'b1, 1'b0, g);
      push_exp(1'b1, wr, da, ds);
      n = 1;
    end else begin
      pick(1'b0, 1'b1, g);
      push_exp(1'b0, 1'b0, ia, 32'h0);
      n = 1;
    end
    @(posedge clk); #1;
    dREN   = want_d && (!wr || rd_too);
    dWEN   = want_d && wr;
    daddr  = da;
    dstore = ds;
    iREN   = want_i;
    iaddr  = ia;
    d_done = !want_d;
    i_done = !want_i;
    last   = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("no_strobe_in_request_cycle", 32'(ramREN | ramWEN), 32'd0);
      if (cyc == 2) chk("strobe_one_cycle_after_request", 32'(ramREN | ramWEN), 32'd1);
      if (!dwait) d_done = 1'b1;
      if (!iwait) i_done = 1'b1;
      if (d_done && i_done) begin
        last = cyc;
        break;
      end
      @(posedge clk); #1;
      if (d_done) begin dREN = 1'b0; dWEN = 1'b0; end
      if (i_done) iREN = 1'b0;
    end
    chk("completion_cycle", 32'(last), 32'(n * (L + 2) + extra));
    @(posedge clk); #1;
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
  endtask

  initial begin
    int on_cnt;
    int seen;
    int last;
    int n;
    bit g;
    nrst = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    mode = MODE_NORMAL; lat = 0; exp_err = 1'b0; fair_cnt = 0; err_done = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    nrst = 1'b1;

    // Data read with two BUSY cycles.
    ram_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    do_round(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 2, 0);

    // Simultaneous ifetch and data write: data first, then ifetch.
    do_round(1'b1, 1'b1, 1'b0, 32'h104, 32'h12345678, 1'b1, 32'h108, 1, 0);

    // Randomised traffic over a small shared address window.
    for (int r = 0; r < 150; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_round(kind != 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 15)) << 2, $urandom,
               kind != 0, 32'($urandom_range(0, 15)) << 2,
               $urandom_range(0, 3), 0);
    end

    // Timeout: RAM never answers.
    chk("arb_err_before_timeout", 32'(arb_err), 32'd0);
    mode = MODE_HANG;
    @(posedge clk); #1;
    dREN = 1'b1; daddr = 32'h200;
    on_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ramREN) on_cnt++;
      else if (on_cnt > 0) break;
      @(posedge clk); #1;
    end
    chk("timeout_owning_cycles", 32'(on_cnt), 32'(TO));
    chk("arb_err_after_timeout", 32'(arb_err), 32'd1);
    chk("dwait_after_timeout", 32'(dwait), 32'd1);
    exp_err = 1'b1;
    @(posedge clk); #1;
    dREN = 1'b0;
    @(negedge clk);
    chk("withdraw_drops_strobes", 32'(ramREN | ramWEN), 32'd0);
    fair_cnt = 0;
    @(posedge clk); #1;
    mode = MODE_NORMAL;

    // Asynchronous reset in the middle of an ifetch.
    mode = MODE_HANG;
    @(posedge clk); #1;
    iREN = 1'b1; iaddr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    chk("i_grant_strobe", 32'(ramREN), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_ramREN", 32'(ramREN), 32'd0);
    chk("async_rst_ramaddr", ramaddr, 32'd0);
    chk("async_rst_iwait", 32'(iwait), 32'd1);
    chk("async_rst_dwait", 32'(dwait), 32'd1);
    chk("async_rst_arb_err", 32'(arb_err), 32'd0);
    iREN = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    exp_err = 1'b0;
    fair_cnt = 0;
    mode = MODE_NORMAL;

    // RAM error on the first data attempt; retry completes.
    mode = MODE_ERR1;
    err_done = 1'b0;
    exp_err = 1'b1;
    do_round(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, 1'b0, 32'h0, 0, 2);
    chk("arb_err_sticky", 32'(arb_err), 32'd1);
    mode = MODE_NORMAL;

    // Both requesters held: grant order under contention.
`ifdef ARB_FAIR_EN
    n = 8;
`else
    n = 4;
`endif
    lat = 0;
    for (int k = 0; k < n; k++) begin
      pick(1'b1, 1'b1, g);
      if (g) push_exp(1'b1, 1'b0, 32'h180, 32'h0);
      else push_exp(1'b0, 1'b0, 32'h1C0, 32'h0);
    end
    @(posedge clk); #1;
    dREN = 1'b1; dWEN = 1'b0; iREN = 1'b1;
    daddr = 32'h180; iaddr = 32'h1C0;
    seen = 0;
    last = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (!dwait || !iwait) seen++;
      if (seen == n) begin
        last = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("contention_last_completion", 32'(last), 32'(2 * n));
    @(posedge clk); #1;
    dREN = 1'b0; iREN = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
